// File: rtl/res_accum_pkg.sv
// Shared definitions for the batch accumulator: defaults, total width helper
// and the drop counter type.
`ifndef T
`define T 10
`endif

package res_accum_pkg;

  localparam int N_DEF     = 4;
  localparam int K_DEF     = 4;
  localparam int DEPTH_DEF = 4;

  typedef logic [7:0] drop_cnt_t;

  // Width that holds k results of n+1 bits without loss.
  function automatic int acc_width(input int n, input int k);
    return n + 1 + $clog2(k);
  endfunction

endpackage

// File: rtl/res_accum_if.sv
// Result-in / batch-total-out bundle for res_accum, with helper tasks for
// driving reset and idling cycles from the bench side.
interface res_accum_intf
  import res_accum_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int K     = K_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input logic clk
);
  localparam int W  = acc_width(N, K);
  localparam int FW = $clog2(DEPTH) + 1;

  logic          rst;
  logic [N:0]    res;
  logic          res_vld;
  logic          flush;
  logic [W-1:0]  sum_out;
  logic          sum_vld;
  logic          sum_rdy;
  logic          drop_err;
  drop_cnt_t     drop_cnt;
  logic [FW-1:0] fill;

  // Reset is released on a falling edge so it never races the active edge.
  task automatic reset(input int cycles);
    rst     = 1'b0;
    res_vld = 1'b0;
    flush   = 1'b0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run(input int cycles);
    repeat (cycles) @(posedge clk);
  endtask

  modport master (
    input  clk, sum_out, sum_vld, drop_err, drop_cnt, fill,
    output rst, res, res_vld, flush, sum_rdy,
    import reset, run
  );

  modport slave (
    input  res, res_vld, flush, sum_rdy,
    output sum_out, sum_vld, drop_err, drop_cnt, fill
  );

endinterface

// File: rtl/res_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head is read straight from the
// registered array and forced to zero while empty.
module res_fifo #(
  parameter  int WIDTH = 7,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [PW-1:0]    fill
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr, r_rptr;
  logic             w_rd, w_wr;

  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign fill  = r_wptr - r_rptr;

  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign w_rd = pop & ~empty;
  assign w_wr = push & (~full | w_rd);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + PW'(1);
      if (w_rd) r_rptr <= r_rptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= din;
  end

  assign dout = empty ? '0 : r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/res_accum.sv
// Sums every K valid results into one total, queues totals in a FIFO and
// tracks batches lost when the FIFO cannot take them.
module res_accum
  import res_accum_pkg::*;
#(
  parameter  int N     = N_DEF,
  parameter  int K     = K_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int W     = acc_width(N, K)
) (
  input logic           clk,
  input logic           rst,
  res_accum_intf.slave  bus
);

  localparam int IW = $clog2(K);

  logic [W-1:0]  r_acc;
  logic [IW-1:0] r_idx;
  logic          r_drop_err;
  drop_cnt_t     r_drop_cnt;

  logic [W-1:0]  w_total;
  logic          w_last, w_push, w_pop, w_drop;
  logic          w_empty, w_full;

  assign w_total = r_acc + W'(bus.res);
  // Flush overrides a completing result, so no total is produced then.
  assign w_last  = bus.res_vld & ~bus.flush & (r_idx == IW'(K - 1));
  assign w_pop   = ~w_empty & bus.sum_rdy;
  assign w_push  = w_last & (~w_full | w_pop);
  assign w_drop  = w_last & w_full & ~w_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
      r_idx <= '0;
    end else if (bus.flush) begin
      r_acc <= '0;
      r_idx <= '0;
    end else if (bus.res_vld) begin
      if (w_last) begin
        r_acc <= '0;
        r_idx <= '0;
      end else begin
        r_acc <= w_total;
        r_idx <= r_idx + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_drop_err <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_drop_err <= 1'b1;
      if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  res_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_total),
    .dout  (bus.sum_out),
    .empty (w_empty),
    .full  (w_full),
    .fill  (bus.fill)
  );

  assign bus.sum_vld  = ~w_empty;
  assign bus.drop_err = r_drop_err;
  assign bus.drop_cnt = r_drop_cnt;

endmodule

// File: doc/res_accum.md
Name: res_accum

Overview:
- Downstream consumer of the adder stage's result stream (res[N:0] with res_vld).
- Sums every K consecutive valid results into one batch total.
- Buffers completed totals in a small FIFO and presents them on a valid/ready output interface.
- Detects and counts batches lost to FIFO backpressure, so bench and integration logic can see when the producer outruns the sink.

Parameters:
- N, 4, operand width of the upstream adder; input result width is N+1.
- K, 4, results per batch; must be at least 2 and a power of two.
- DEPTH, 4, number of entries in the output FIFO; must be at least 2 and a power of two.
- W, N+1+$clog2(K), width of a batch total (derived, not to be overridden).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- res  in  N+1  upstream sum; sampled only when res_vld=1.
- res_vld  in  1  upstream result strobe; no backpressure upstream.
- flush  in  1  synchronous; discards the partial batch.
- sum_out  out  W  batch total at the FIFO head.
- sum_vld  out  1  FIFO non-empty.
- sum_rdy  in  1  consumer accepts sum_out when sum_vld & sum_rdy.
- drop_err  out  1  sticky; set when a batch is dropped.
- drop_cnt  out  8  number of dropped batches; saturates at 255.
- fill  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
Reset (rst=0):
- Asynchronous; clears the accumulator, batch counter, FIFO pointers and error state.
- While reset is asserted: sum_vld=0, sum_out=0, drop_err=0, drop_cnt=0, fill=0.
- Reset asserted mid-batch or with a non-empty FIFO discards all of that data.

Accumulate:
- The block has no explicit state machine. State is an accumulator acc[W-1:0] and a batch counter idx[$clog2(K)-1:0].
- On a res_vld=1 cycle with idx<K-1: acc += res (zero-extended to W) and idx += 1.
- On a res_vld=1 cycle with idx=K-1: total = acc + res is the batch result. acc and idx return to 0 in that same cycle, so the next result starts a fresh batch with no gap.
- While res_vld=0, the value on res is ignored.

Width:
- W bits hold K*(2^(N+1)-1) without loss. No overflow check is required.

Push:
- A completed batch is written into the FIFO on the same clock edge.
- sum_vld rises in the cycle after the K-th res_vld when the FIFO was empty (latency of 1 cycle).

Output handshake:
- sum_out and sum_vld come from registered FIFO head state.
- A pop occurs when sum_vld & sum_rdy.
- While sum_vld=1 and sum_rdy=0, sum_out is held stable.
- Entries leave in completion order.

Full FIFO:
- A push is accepted if fill<DEPTH, or if fill=DEPTH and a pop occurs in the same cycle (simultaneous push and pop when full is legal).
- Otherwise the total is dropped: drop_err is set (sticky until reset), and drop_cnt increments unless it is already 255.
- A dropped batch never corrupts stored entries.

Empty FIFO:
- With sum_vld=0, sum_rdy is ignored.
- A push into an empty FIFO is not visible as a pop in the same cycle (no fall-through).

Simultaneous push and pop (not full):
- fill is unchanged; both pointers advance.

Flush:
- flush=1 zeroes acc and idx. FIFO contents are unaffected.
- flush=1 together with res_vld=1: flush wins and that result is discarded, even when idx=K-1. No push occurs.

Pointer wrap-around:
- Read and write pointers are $clog2(DEPTH)+1 bits wide.
- Full and empty are decided by comparing the MSBs with the remaining pointer bits equal.

Decomposition:
- Shared package:
  - `T (clock period, existing).
  - Default localparams for N, K and DEPTH.
  - A function acc_width(n,k) returning n+1+$clog2(k).
  - A typedef for the drop counter (8-bit logic).
- Sub-module res_fifo:
  - Parameterised synchronous FIFO (WIDTH, DEPTH) with active-low async reset.
  - Ports: push, pop, din, dout, empty, full, fill.
- res_accum instantiates res_fifo and contains only the accumulate, drop and flush logic.
- Add a matching interface, res_accum_intf, with reset() and run() tasks for the bench.

Test Plan (N=4, K=4, DEPTH=4, W=7):
- Reset: hold rst=0 for 3 cycles, drive random res with res_vld=1 -> sum_vld=0, drop_err=0, drop_cnt=0, fill=0 throughout.
- Basic batch: res=1,2,3,4 on consecutive res_vld cycles with sum_rdy=1 -> sum_out=10 with sum_vld=1 for exactly one cycle, starting the cycle after the 4th strobe; fill returns to 0.
- Maximum values with gaps: res=30 four times, res_vld toggling and res=31 driven while res_vld=0 -> single total of 120.
- Backpressure and drop: sum_rdy=0, five batches of res=1 -> fill=4, 5th batch dropped, drop_err=1, drop_cnt=1. Then sum_rdy=1 -> four totals of 4 over 4 consecutive cycles, then sum_vld=0.
- Full with simultaneous pop: FIFO full, sum_rdy=1 in the cycle a batch completes -> new total accepted, drop_cnt unchanged, fill stays 4.
- Flush and reset mid-batch:
  - res=9,9, then flush, then res=5 x4 -> total 20.
  - Assert rst after 2 results -> no total emitted; the next 4 results form a fresh batch.
